// File: rtl/countermodn_chain_pkg.sv
// Shared types and digit arithmetic for the modulo-N counter chain.
// Digits are handled as 8-bit values so one set of functions covers every legal modulus.
package countermodn_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int MAX_MODULUS = 256;
    localparam int MAX_DIGITS  = 8;

    // Wrap is explicit so non-power-of-two moduli never rely on 2^W overflow.
    function automatic logic [7:0] digit_next(input logic [7:0] cur, input dir_t dir, input int modulus);
        logic [7:0] top;
        top = 8'(modulus - 1);
        if (dir == DIR_UP) begin
            digit_next = (cur == top) ? 8'd0 : cur + 8'd1;
        end else begin
            digit_next = (cur == 8'd0) ? top : cur - 8'd1;
        end
    endfunction

    function automatic logic is_terminal(input logic [7:0] cur, input dir_t dir, input int modulus);
        if (dir == DIR_UP) begin
            is_terminal = (cur == 8'(modulus - 1));
        end else begin
            is_terminal = (cur == 8'd0);
        end
    endfunction

endpackage

// File: rtl/countermodn_chain_if.sv
// Control and data bundle of one counter chain; the counter is the slave side.
interface countermodn_chain_if #(
    parameter int MODULUS = 7,
    parameter int DIGITS  = 2
);
    localparam int W = $clog2(MODULUS);

    logic                  enable;
    logic                  up;
    logic                  load;
    logic [DIGITS*W-1:0]   load_value;
    logic [DIGITS*W-1:0]   value;
    logic                  tc;

    modport master (
        output enable, up, load, load_value,
        input  value, tc
    );

    modport slave (
        input  enable, up, load, load_value,
        output value, tc
    );
endinterface

// File: rtl/countermodn_chain_digit.sv
// One modulo-N digit: registered value with load clamp, step and terminal flag.
module countermodn_digit
    import countermodn_pkg::*;
#(
    parameter int MODULUS = 7
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         step,
    input  logic                         up,
    input  logic                         load,
    input  logic [$clog2(MODULUS)-1:0]   load_digit,
    output logic [$clog2(MODULUS)-1:0]   digit,
    output logic                         at_term
);
    localparam int W = $clog2(MODULUS);

    logic [W-1:0] digit_reg;
    logic [W-1:0] load_clamped;
    logic [W-1:0] step_value;
    logic [7:0]   cur_wide;
    logic [7:0]   next_wide;

    assign cur_wide  = 8'(digit_reg);
    assign next_wide = digit_next(cur_wide, dir_t'(up), MODULUS);
    assign step_value = next_wide[W-1:0];

    // Out-of-range load data would leave the digit in an unreachable state.
    assign load_clamped = (int'(load_digit) >= MODULUS) ? '0 : load_digit;

    always_ff @(posedge clock) begin
        if (reset) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= load_clamped;
        end else if (step) begin
            digit_reg <= step_value;
        end
    end

    assign digit   = digit_reg;
    assign at_term = is_terminal(cur_wide, dir_t'(up), MODULUS);

endmodule

// File: rtl/countermodn_chain.sv
// Cascade of DIGITS modulo-MODULUS digits with up/down, parallel load and terminal count.
module countermodn_chain
    import countermodn_pkg::*;
#(
    parameter int MODULUS = 7,
    parameter int DIGITS  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    countermodn_chain_if.slave   bus
);
    localparam int W = $clog2(MODULUS);

    if (MODULUS < 2 || MODULUS > MAX_MODULUS) begin : g_bad_modulus
        $error("countermodn_chain: MODULUS must be in 2..256");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("countermodn_chain: DIGITS must be in 1..8");
    end

    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] at_term;

    // carry[k] is enable qualified by every lower digit sitting at its terminal value.
    assign carry[0] = bus.enable;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [W-1:0] digit_q;

        countermodn_digit #(
            .MODULUS (MODULUS)
        ) u_digit (
            .clock      (clock),
            .reset      (reset),
            .step       (carry[gi]),
            .up         (bus.up),
            .load       (bus.load),
            .load_digit (bus.load_value[gi*W +: W]),
            .digit      (digit_q),
            .at_term    (at_term[gi])
        );

        assign bus.value[gi*W +: W] = digit_q;
        assign carry[gi+1]          = carry[gi] & at_term[gi];
    end

    assign bus.tc = carry[DIGITS];

endmodule

// File: tb/tb_countermodn_chain.sv
// Directed bench: a 7x2 chain, a second 7x2 chain cascaded from its tc, and an 8x1 chain.
module tb_countermodn_chain;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    countermodn_chain_if #(.MODULUS(7), .DIGITS(2)) bus_a ();
    countermodn_chain_if #(.MODULUS(7), .DIGITS(2)) bus_b ();
    countermodn_chain_if #(.MODULUS(8), .DIGITS(1)) bus_c ();

    assign bus_b.enable = bus_a.tc;

    countermodn_chain #(.MODULUS(7), .DIGITS(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    countermodn_chain #(.MODULUS(7), .DIGITS(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    countermodn_chain #(.MODULUS(8), .DIGITS(1)) dut_c (
        .clock (clock),
        .reset (reset),
        .bus   (bus_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pack two base-7 digits into the 6-bit value layout (3 bits per digit).
    function automatic int pk(input int hi, input int lo);
        return hi * 8 + lo;
    endfunction

    initial begin
        reset = 1'b1;
        bus_a.enable = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_value = '0;
        bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.load_value = '0;
        bus_c.enable = 1'b0; bus_c.up = 1'b1; bus_c.load = 1'b0; bus_c.load_value = '0;

        // Reset, full up count and wrap, with the cascaded chain watching tc
        tick(); tick();
        check("reset_a", int'(bus_a.value), 0);
        check("reset_b", int'(bus_b.value), 0);
        reset = 1'b0; bus_a.enable = 1'b1; bus_a.up = 1'b1;
        #1;
        for (int i = 0; i < 49; i++) begin
            check($sformatf("up_val[%0d]", i), int'(bus_a.value), pk(i / 7, i % 7));
            check($sformatf("up_tc[%0d]", i), int'(bus_a.tc), (i == 48) ? 1 : 0);
            if (i == 47) check("casc_before_wrap", int'(bus_b.value), 0);
            tick();
        end
        check("up_wrap", int'(bus_a.value), 0);
        check("casc_once", int'(bus_b.value), 1);

        // Down count from zero
        reset = 1'b1; tick(); reset = 1'b0;
        bus_a.enable = 1'b1; bus_a.up = 1'b0;
        #1;
        check("down_tc_at_00", int'(bus_a.tc), 1);
        tick();
        check("down_66", int'(bus_a.value), pk(6, 6));
        check("down_tc_at_66", int'(bus_a.tc), 0);
        tick();
        check("down_65", int'(bus_a.value), pk(6, 5));

        // Enable hold, then mid-count reset overriding load and enable
        reset = 1'b1; tick(); reset = 1'b0;
        bus_a.up = 1'b1; bus_a.enable = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        check("count_to_23", int'(bus_a.value), pk(2, 3));
        bus_a.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold[%0d]", i), int'(bus_a.value), pk(2, 3));
        end
        check("hold_tc", int'(bus_a.tc), 0);
        reset = 1'b1; bus_a.enable = 1'b1; bus_a.load = 1'b1; bus_a.load_value = 6'(pk(4, 4));
        tick();
        reset = 1'b0; bus_a.load = 1'b0; bus_a.enable = 1'b0;
        check("reset_priority", int'(bus_a.value), 0);

        // Load with an out-of-range digit clamps that digit to 0
        bus_a.load = 1'b1; bus_a.enable = 1'b1; bus_a.up = 1'b1; bus_a.load_value = 6'(pk(5, 7));
        tick();
        check("load_clamp", int'(bus_a.value), pk(5, 0));
        bus_a.load = 1'b0;
        tick();
        check("after_load_step", int'(bus_a.value), pk(5, 1));

        // Direction change on a carry boundary
        bus_a.load = 1'b1; bus_a.load_value = 6'(pk(3, 6));
        tick();
        check("load_36", int'(bus_a.value), pk(3, 6));
        bus_a.load = 1'b0; bus_a.up = 1'b1;
        tick();
        check("up_carry_40", int'(bus_a.value), pk(4, 0));
        bus_a.up = 1'b0;
        tick();
        check("down_borrow_36", int'(bus_a.value), pk(3, 6));

        // Load during a tc cycle: load wins, tc still follows the current state
        bus_a.load = 1'b1; bus_a.load_value = 6'(pk(6, 6));
        tick();
        bus_a.up = 1'b1; bus_a.load_value = 6'(pk(1, 2));
        #1;
        check("tc_with_load", int'(bus_a.tc), 1);
        tick();
        check("load_beats_wrap", int'(bus_a.value), pk(1, 2));
        bus_a.load = 1'b0; bus_a.enable = 1'b0;

        // Power-of-two modulus: wrap is still at MODULUS-1
        reset = 1'b1; tick(); reset = 1'b0;
        bus_c.enable = 1'b1; bus_c.up = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("p2_val[%0d]", i), int'(bus_c.value), i);
            check($sformatf("p2_tc[%0d]", i), int'(bus_c.tc), (i == 7) ? 1 : 0);
            tick();
        end
        check("p2_wrap", int'(bus_c.value), 0);
        bus_c.up = 1'b0;
        tick();
        check("p2_down_wrap", int'(bus_c.value), 7);
        bus_c.up = 1'b1;
        #1;
        check("p2_tc_at_7", int'(bus_c.tc), 1);
        bus_c.enable = 1'b0;
        #1;
        check("p2_tc_gated", int'(bus_c.tc), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
